// File: rtl/shift_pkg.sv
// Purpose: shared constants, opcode/state encodings and effective-count helper for the shift unit.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
package shift_pkg;

    // Operand/result width; the datapath only supports 8.
    localparam int DATA_W    = 8;
    // Largest useful shift distance for the non-rotating opcodes.
    localparam int MAX_SHIFT = 8;

    // Opcode encodings as presented by decode.
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Sequencer state encoding.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Number of single-bit positions a request really needs.
    // Rotates are periodic in 8, so only the low three bits matter; logical and
    // arithmetic shifts saturate at 8 because further steps cannot change the value.
    function automatic logic [3:0] eff_count(input logic [1:0] op, input logic [7:0] shamt);
        logic [3:0] n;
        if (op == OP_ROR) begin
            n = {1'b0, shamt[2:0]};
        end else if (shamt >= 8'(MAX_SHIFT)) begin
            n = 4'(MAX_SHIFT);
        end else begin
            n = shamt[3:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Purpose: combinational one-step shifter (1 position, or 4 when the fast path is built).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports: op (opcode), data (current working value), by4 (request a 4-position step),
//        next_dat (value after the step).
// Build option: SHIFT_SEQ_FAST4_EN enables the 4-position datapath; otherwise by4 is ignored.
module shift_step
    import shift_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] data,
    input  logic              by4,
    output logic [DATA_W-1:0] next_dat
);

    logic [DATA_W-1:0] one_dat;

    always_comb begin
        one_dat = data;
        case (op)
            OP_SLL:  one_dat = {data[DATA_W-2:0], 1'b0};
            OP_SRL:  one_dat = {1'b0, data[DATA_W-1:1]};
            OP_SRA:  one_dat = {data[DATA_W-1], data[DATA_W-1:1]};
            OP_ROR:  one_dat = {data[0], data[DATA_W-1:1]};
            default: one_dat = data;
        endcase
    end

`ifdef SHIFT_SEQ_FAST4_EN
    logic [DATA_W-1:0] four_dat;

    // Same fill rules as the single step, applied across four bit positions at once.
    always_comb begin
        four_dat = data;
        case (op)
            OP_SLL:  four_dat = {data[DATA_W-5:0], 4'b0000};
            OP_SRL:  four_dat = {4'b0000, data[DATA_W-1:4]};
            OP_SRA:  four_dat = {{4{data[DATA_W-1]}}, data[DATA_W-1:4]};
            OP_ROR:  four_dat = {data[3:0], data[DATA_W-1:4]};
            default: four_dat = data;
        endcase
    end

    assign next_dat = by4 ? four_dat : one_dat;
`else
    // Single-step build: the 4-position request has nowhere to go.
    logic unused_by4;
    assign unused_by4 = by4;
    assign next_dat   = one_dat;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Purpose: multi-cycle shift unit (SLL/SRL/SRA/ROR) iterating a stepped shift per clock.
// Latency: 1 cycle for a zero effective count, else n+1 cycles START-to-DONE (fewer with fast path).
// Backpressure: START is ignored while BUSY; a new START is accepted in the DONE cycle.
//
// Ports: CLK, RESET (sync, active-low), START/OPCODE/DATA_IN/SHAMT request inputs,
//        BUSY (shifting in progress), DONE (one-cycle completion pulse), RESULT (working/result register).
// Build option: SHIFT_SEQ_FAST4_EN takes 4-position steps while at least 4 positions remain.
module shift_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        OPCODE,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [7:0]        SHAMT,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RESULT
);
    import shift_pkg::*;

    logic [0:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [1:0]        op_q,     op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q,   done_d;

    logic              step_by4;
    logic [CNT_W-1:0]  step_amt;
    logic [DATA_W-1:0] step_dat;

`ifdef SHIFT_SEQ_FAST4_EN
    // Take the wide step only while it cannot overshoot the remaining count.
    assign step_by4 = (cnt_q >= CNT_W'(4));
    assign step_amt = step_by4 ? CNT_W'(4) : CNT_W'(1);
`else
    assign step_by4 = 1'b0;
    assign step_amt = CNT_W'(1);
`endif

    shift_step u_step (
        .op       (op_q),
        .data     (result_q),
        .by4      (step_by4),
        .next_dat (step_dat)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    op_d     = OPCODE;
                    result_d = DATA_IN;
                    cnt_d    = CNT_W'(eff_count(OPCODE, SHAMT));
                    // Nothing to shift: complete straight from IDLE with the operand as result.
                    if (cnt_d == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                result_d = step_dat;
                cnt_d    = cnt_q - step_amt;
                if (cnt_d == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset has priority so an in-flight shift is dropped without a DONE pulse.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_SLL;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = (state_q == ST_SHIFT);
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Purpose: directed self-checking bench for shift_sequencer (default and fast-path builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_sequencer;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [1:0] OPCODE;
    logic [7:0] DATA_IN;
    logic [7:0] SHAMT;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;

    int err_cnt = 0;
    int chk_cnt = 0;

    shift_sequencer #(.DATA_W(8), .CNT_W(4)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .OPCODE  (OPCODE),
        .DATA_IN (DATA_IN),
        .SHAMT   (SHAMT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        chk_cnt++;
        if (obs !== exp_val) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_val);
        end
    endtask

    // Shift cycles expected for an effective count n.
    function automatic int shift_cycles(input int n);
`ifdef SHIFT_SEQ_FAST4_EN
        return (n / 4) + (n % 4);
`else
        return n;
`endif
    endfunction

    // Caller is positioned just after a negedge. Issues one request, then waits for DONE
    // (bounded) and ends at the negedge of the DONE cycle, so the next request is back-to-back.
    task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] dat,
                          input logic [7:0] sh, input int n, input logic [7:0] exp_res);
        int cycles;
        int busy_cyc;
        int want;
        want     = shift_cycles(n);
        START    = 1'b1;
        OPCODE   = op;
        DATA_IN  = dat;
        SHAMT    = sh;
        @(posedge CLK);
        #1;
        START    = 1'b0;
        cycles   = 0;
        busy_cyc = 0;
        while (cycles < 20) begin
            @(negedge CLK);
            cycles++;
            if (DONE) break;
            if (BUSY) busy_cyc++;
        end
        check({tag, "_lat"},  cycles,   want + 1);
        check({tag, "_busy"}, busy_cyc, want);
        check({tag, "_res"},  RESULT,   exp_res);
        check({tag, "_bsyd"}, BUSY,     1'b0);
    endtask

    initial begin
        RESET   = 1'b0;
        START   = 1'b0;
        OPCODE  = 2'b00;
        DATA_IN = 8'h00;
        SHAMT   = 8'h00;
        repeat (2) @(negedge CLK);
        check("rst_busy",   BUSY,   1'b0);
        check("rst_done",   DONE,   1'b0);
        check("rst_result", RESULT, 8'h00);
        RESET = 1'b1;
        @(negedge CLK);

        // Back-to-back chain: each request is issued in the previous DONE cycle.
        do_req("srl_b4_3",   2'b01, 8'hB4, 8'd3,   3, 8'h16);
        do_req("sra_90_2",   2'b10, 8'h90, 8'd2,   2, 8'hE4);
        do_req("sra_80_200", 2'b10, 8'h80, 8'd200, 8, 8'hFF);
        do_req("sll_81_200", 2'b00, 8'h81, 8'd200, 8, 8'h00);
        do_req("ror_01_9",   2'b11, 8'h01, 8'd9,   1, 8'h80);
        do_req("ror_01_8",   2'b11, 8'h01, 8'd8,   0, 8'h01);
        do_req("srl_5a_0",   2'b01, 8'h5A, 8'd0,   0, 8'h5A);
        do_req("ror_96_7",   2'b11, 8'h96, 8'd7,   7, 8'h2D);
        do_req("sll_0f_4",   2'b00, 8'h0F, 8'd4,   4, 8'hF0);
        do_req("sll_81_7",   2'b00, 8'h81, 8'd7,   7, 8'h80);
        do_req("sll_81_8",   2'b00, 8'h81, 8'd8,   8, 8'h00);

        // DONE must drop after its single cycle when nothing new is issued.
        @(negedge CLK);
        check("idle_done",   DONE,   1'b0);
        check("idle_busy",   BUSY,   1'b0);
        check("idle_result", RESULT, 8'h00);

        // Abort: START while BUSY is ignored, then reset in shift cycle 2.
        START   = 1'b1;
        OPCODE  = 2'b00;
        DATA_IN = 8'hFF;
        SHAMT   = 8'd5;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        check("abt_c1_busy", BUSY,   1'b1);
        check("abt_c1_res",  RESULT, 8'hFF);
        START   = 1'b1;
        OPCODE  = 2'b01;
        DATA_IN = 8'h00;
        SHAMT   = 8'd0;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        check("abt_c2_busy", BUSY, 1'b1);
        check("abt_c2_done", DONE, 1'b0);
`ifdef SHIFT_SEQ_FAST4_EN
        check("abt_c2_res", RESULT, 8'hF0);
`else
        check("abt_c2_res", RESULT, 8'hFE);
`endif
        RESET = 1'b0;
        @(negedge CLK);
        check("abt_rst_busy", BUSY,   1'b0);
        check("abt_rst_res",  RESULT, 8'h00);
        check("abt_rst_done", DONE,   1'b0);
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("abt_no_done", DONE, 1'b0);
            check("abt_no_busy", BUSY, 1'b0);
        end

        do_req("post_sll_03_2", 2'b00, 8'h03, 8'd2, 2, 8'h0C);
        @(negedge CLK);
        check("post_done_drop", DONE, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift execution unit in the 8-bit processor's ALU shift path. Accepts a shift request (opcode, operand, amount) from the instruction decode/operand stage and iterates one bit position per clock, or four with the fast path. It raises a one-cycle completion pulse with the registered result for register-file writeback. It covers logical left, logical right, arithmetic right and rotate right.

## Interface
- DATA_W, 8, operand/result width; only 8 is supported.
- CNT_W, 4, width of the internal remaining-shift counter.

- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset (asserted when 0).
- START  input  1  request strobe; sampled only when not BUSY.
- OPCODE  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- DATA_IN  input  8  operand, latched on an accepted START.
- SHAMT  input  8  shift amount, latched on an accepted START.
- BUSY  output  1  high while shifting is in progress.
- DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  8  working/result register.

## Operation
- States: IDLE, SHIFT.
- **Effective count**, computed at START:
  - SLL/SRL/SRA: min(SHAMT, 8); any SHAMT ≥ 8 clamps to 8.
  - ROR: SHAMT[2:0].
- **IDLE with START high** (accepted):
  - Latch OPCODE, DATA_IN → RESULT, and the effective count.
  - If count = 0: DONE←1, remain IDLE; RESULT = DATA_IN.
  - Else: go to SHIFT.
- **SHIFT, each edge:**
  - RESULT ← single-step shift of RESULT; count ← count − step.
  - If count − step = 0: DONE←1, go to IDLE.
- **Step semantics:**
  - SLL: zero fill at the LSB.
  - SRL: zero fill at the MSB.
  - SRA: replicate bit 7.
  - ROR: bit 0 → bit 7.
- Step = 1, except as given under Configuration.
- BUSY = (state == SHIFT), combinational from state.
- DONE is registered and high for exactly one cycle per accepted START.
- START while BUSY is ignored and has no effect on the latched operands.
- START in IDLE during a cycle where DONE is high is accepted.
- RESULT holds its final value until the next accepted START. During SHIFT it shows intermediate values and is not valid.
- **Reset (RESET = 0 at an edge):** state IDLE, RESULT 8'h00, DONE 0, BUSY 0, count 0.
- Reset mid-operation aborts the shift. No DONE pulse is produced for the aborted request.

## Timing
- START accepted at edge E0.
- Effective count n = 0: DONE high in the cycle after E0 (latency 1).
- n ≥ 1, no fast path: n SHIFT edges; DONE high in the cycle after edge E0+n.
- BUSY is high for n cycles.
- Worst case (SHAMT ≥ 8): 8 shift cycles, 9 cycles START-to-DONE.
- Back-to-back throughput: a new START may be issued in the DONE cycle.

## Configuration
- Macro: SHIFT_SEQ_FAST4_EN.
- **Defined:** while remaining count ≥ 4, step = 4 (one 4-position shift per edge, same fill rules); otherwise step = 1.
  - Shift cycles = (n div 4) + (n mod 4).
  - Worst case n = 7 takes 4 cycles; n = 8 takes 2.
- **Undefined:** step is always 1. The 4-position datapath is not instantiated.

## Structure
- Shared package shift_pkg:
  - opcode localparams OP_SLL/OP_SRL/OP_SRA/OP_ROR;
  - DATA_W;
  - MAX_SHIFT = 8;
  - state encoding (IDLE = 0, SHIFT = 1).
- One sub-module, shift_step: combinational, takes (op, data, by4) and returns the next RESULT value for a 1- or 4-position step.
- The FSM, counter and registers live in shift_sequencer.

## Test plan
- SRL, DATA_IN 8'hB4, SHAMT 3 → BUSY high 3 cycles, DONE once, RESULT 8'h16. With fast path: 3 cycles.
- SRA, 8'h90, SHAMT 2 → RESULT 8'hE4. SRA, 8'h80, SHAMT 8'd200 → RESULT 8'hFF after 8 cycles (2 with fast path).
- SLL, 8'h81, SHAMT 8'd200 → count clamped to 8, RESULT 8'h00.
- ROR, 8'h01, SHAMT 9 → 1 cycle, RESULT 8'h80. ROR, 8'h01, SHAMT 8 → DONE the cycle after START, RESULT 8'h01, BUSY never high.
- SRL, 8'h5A, SHAMT 0 → DONE the cycle after START, RESULT 8'h5A.
- START (SLL, 8'hFF, 5) accepted. START pulsed while BUSY → ignored. RESET low at shift cycle 2 → BUSY 0, RESULT 8'h00, no DONE. A following request completes normally.
